// File: rtl/lfsr_arb_pkg.sv
// Shared types, default constants and the Galois LFSR step function for lfsr_share_arbiter.
package lfsr_arb_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } arb_state_e;

  localparam logic [15:0] LFSR_POLY_DEFAULT = 16'h8BB7;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state, input logic [15:0] poly);
    return {state[14:0], 1'b0} ^ (state[15] ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating pointer plus combinational one-hot grant selection.
module rr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;

  // First requester found at or after ptr (modulo NUM_REQ) wins.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    sel   = ptr_q;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = PW'((32'(ptr_q) + off) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        sel        = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_o) begin
      ptr_d = ((32'(sel) + 32'd1) == NUM_REQ) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lfsr_share_arbiter.sv
// One shared 16-bit Galois LFSR handed out word-by-word to round-robin-arbitrated requesters.
// Optional grant counter output enabled by defining LFSR_ARB_STATS_EN.
module lfsr_share_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter logic [15:0] POLY          = LFSR_POLY_DEFAULT,
  parameter logic [15:0] SEED          = LFSR_SEED_DEFAULT,
  parameter int unsigned WARMUP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  input  logic               seed_load,
  input  logic [15:0]        seed_value,
  output logic               busy
`ifdef LFSR_ARB_STATS_EN
  ,
  output logic [15:0]        grant_count
`endif
);

  localparam logic [7:0] WCNT_INIT = 8'(WARMUP_CYCLES);

  arb_state_e         fsm_q, fsm_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        lfsr_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic [15:0]        rnd_data_q, rnd_data_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any;
  logic               do_grant;

  assign lfsr_nxt = lfsr_step(lfsr_q, POLY);
  // A requester's own grant cycle masks its request so it cannot be granted twice in a row.
  assign eligible = req & ~gnt_q;
  assign do_grant = (fsm_q == SERVE) && !seed_load && arb_any;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (reset_n),
    .req_i    (eligible),
    .advance_i(do_grant),
    .gnt_o    (arb_gnt),
    .any_o    (arb_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= WARMUP;
      wcnt_q      <= WCNT_INIT;
      lfsr_q      <= SEED;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      busy_q      <= (WARMUP_CYCLES != 0);
    end else begin
      fsm_q       <= fsm_d;
      wcnt_q      <= wcnt_d;
      lfsr_q      <= lfsr_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    wcnt_d = wcnt_q;
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_value == '0) ? SEED : seed_value;
      fsm_d  = WARMUP;
      wcnt_d = WCNT_INIT;
    end else begin
      case (fsm_q)
        WARMUP: begin
          if (wcnt_q == '0) begin
            fsm_d = SERVE;
          end else begin
            lfsr_d = lfsr_nxt;
            wcnt_d = wcnt_q - 1'b1;
            if (wcnt_q == 8'd1) fsm_d = SERVE;
          end
        end
        SERVE: begin
          if (arb_any) lfsr_d = lfsr_nxt;
        end
        default: fsm_d = WARMUP;
      endcase
    end
  end

  always_comb begin
    gnt_d       = do_grant ? arb_gnt : '0;
    rnd_valid_d = do_grant;
    rnd_data_d  = do_grant ? lfsr_nxt : rnd_data_q;
    busy_d      = (fsm_d == WARMUP) && (wcnt_d != '0);
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign busy      = busy_q;

`ifdef LFSR_ARB_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_q + 16'(rnd_valid_q);
  end

  assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Self-checking bench for lfsr_share_arbiter: directed test-plan scenarios plus randomized traffic vs a reference model.
module tb_lfsr_share_arbiter;

  localparam int          N = 4;
  localparam logic [15:0] P = 16'h8BB7;
  localparam logic [15:0] S = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic        seed_load = 1'b0;
  logic [15:0] seed_value = 16'h0000;
  logic        busy;

  logic [3:0]  req_w = 4'b0000;
  logic [3:0]  gnt_w;
  logic        rnd_valid_w;
  logic [15:0] rnd_data_w;
  logic        busy_w;

`ifdef LFSR_ARB_STATS_EN
  logic [15:0] grant_count;
  logic [15:0] grant_count_w;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_share_arbiter #(
    .NUM_REQ(4), .POLY(16'h8BB7), .SEED(16'hFFFF), .WARMUP_CYCLES(0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
    .rnd_data(rnd_data), .seed_load(seed_load), .seed_value(seed_value), .busy(busy)
`ifdef LFSR_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  lfsr_share_arbiter #(
    .NUM_REQ(4), .POLY(16'h8BB7), .SEED(16'hFFFF), .WARMUP_CYCLES(2)
  ) u_dut_w (
    .clk(clk), .reset_n(reset_n), .req(req_w), .gnt(gnt_w), .rnd_valid(rnd_valid_w),
    .rnd_data(rnd_data_w), .seed_load(1'b0), .seed_value(16'h0000), .busy(busy_w)
`ifdef LFSR_ARB_STATS_EN
    , .grant_count(grant_count_w)
`endif
  );

  // Reference model of the WARMUP_CYCLES=0 instance, expressed as per-grant bookkeeping.
  logic [15:0] m_lfsr;
  int          m_ptr;
  bit          m_warm;
  int          m_wleft;
  logic [3:0]  e_gnt;
  logic        e_valid;
  logic [15:0] e_data;
  logic        e_busy;
  logic [15:0] e_cnt;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    int unsigned v;
    v = 32'(s) * 32'd2;
    if (v >= 32'h10000) v = (v - 32'h10000) ^ 32'(P);
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_lfsr  = S;
    m_ptr   = 0;
    m_warm  = 1'b1;
    m_wleft = 0;
    e_gnt   = 4'b0000;
    e_valid = 1'b0;
    e_data  = 16'h0000;
    e_busy  = 1'b0;
    e_cnt   = 16'h0000;
  endtask

  task automatic model_edge();
    logic [3:0] elig;
    int k;
    e_cnt = e_cnt + 16'(e_valid);
    if (seed_load) begin
      m_lfsr  = (seed_value == 16'h0000) ? S : seed_value;
      m_warm  = 1'b1;
      m_wleft = 0;
      e_gnt   = 4'b0000;
      e_valid = 1'b0;
    end else if (m_warm) begin
      if (m_wleft > 0) begin
        m_lfsr  = ref_step(m_lfsr);
        m_wleft = m_wleft - 1;
      end
      if (m_wleft == 0) m_warm = 1'b0;
      e_gnt   = 4'b0000;
      e_valid = 1'b0;
    end else begin
      elig = req & ~e_gnt;
      k = -1;
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (m_ptr + j) % N;
        if (k < 0 && ((elig >> idx) & 4'b0001) != 4'b0000) k = idx;
      end
      if (k >= 0) begin
        m_lfsr  = ref_step(m_lfsr);
        e_data  = m_lfsr;
        e_gnt   = 4'b0001 << k;
        e_valid = 1'b1;
        m_ptr   = (k + 1) % N;
      end else begin
        e_gnt   = 4'b0000;
        e_valid = 1'b0;
      end
    end
    e_busy = m_warm && (m_wleft > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n    = 1'b0;
    req        = 4'b0000;
    req_w      = 4'b0000;
    seed_load  = 1'b0;
    seed_value = 16'h0000;
    #10;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    req     = 4'b1111;
    #3;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
    total++; if (rnd_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", rnd_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_w0: got %b want 0", busy); end
    total++; if (busy_w !== 1'b1) begin bad++; $display("FAIL reset_busy_w2: got %b want 1", busy_w); end
`ifdef LFSR_ARB_STATS_EN
    total++; if (grant_count !== 16'h0000) begin bad++; $display("FAIL reset_count: got %h want 0000", grant_count); end
`endif
    #7;
    req     = 4'b0000;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_requester();
    logic [15:0] exp_q[$];
    logic [3:0]  want_gnt;
    exp_q = '{16'h7449, 16'hE892, 16'h5A93};
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      tick();
      want_gnt = (c >= 2 && (c % 2) == 0) ? 4'b0001 : 4'b0000;
      total++; if (gnt !== want_gnt) begin bad++; $display("FAIL single_gnt c=%0d: got %b want %b", c, gnt, want_gnt); end
      total++; if (gnt !== e_gnt || rnd_valid !== e_valid) begin bad++; $display("FAIL single_model c=%0d: got %b/%b want %b/%b", c, gnt, rnd_valid, e_gnt, e_valid); end
      if (rnd_valid === 1'b1 && exp_q.size() > 0) begin
        total++; if (rnd_data !== exp_q[0]) begin bad++; $display("FAIL single_data: got %h want %h", rnd_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_words: got %0d missing want 0", exp_q.size()); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_q[$];
    logic [3:0]  want_gnt;
    exp_q = '{16'h7449, 16'hE892, 16'h5A93};
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      tick();
      want_gnt = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
      total++; if (gnt !== want_gnt) begin bad++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt, want_gnt); end
      total++; if (rnd_valid !== (c >= 2)) begin bad++; $display("FAIL rr_valid c=%0d: got %b want %b", c, rnd_valid, (c >= 2)); end
      if (rnd_valid === 1'b1) begin
        total++; if (rnd_data !== e_data) begin bad++; $display("FAIL rr_model_data c=%0d: got %h want %h", c, rnd_data, e_data); end
        if (exp_q.size() > 0) begin
          total++; if (rnd_data !== exp_q[0]) begin bad++; $display("FAIL rr_data: got %h want %h", rnd_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_zero_seed();
    bit seen;
    tick();
    seed_load  = 1'b1;
    seed_value = 16'h0000;
    tick();
    seed_load = 1'b0;
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL zseed_valid: got %b want 0", rnd_valid); end
    req  = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (rnd_valid === 1'b1) begin
        seen = 1'b1;
        total++; if (rnd_data !== 16'h7449) begin bad++; $display("FAIL zseed_data: got %h want 7449", rnd_data); end
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL zseed_gnt: got %b want 0100", gnt); end
        req = 4'b0000;
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL zseed_timeout: got no grant want grant"); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_seed_collision();
    bit seen;
    req = 4'b0001;
    tick();
    tick();
    req = 4'b0000;
    tick();
    seed_load  = 1'b1;
    seed_value = 16'hFFFF;
    req        = 4'b0100;
    tick();
    seed_load = 1'b0;
    total++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) begin bad++; $display("FAIL collide_nogrant: got %b/%b want 0000/0", gnt, rnd_valid); end
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (rnd_valid === 1'b1) begin
        seen = 1'b1;
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL collide_gnt: got %b want 0100", gnt); end
        total++; if (rnd_data !== 16'h7449) begin bad++; $display("FAIL collide_data: got %h want 7449", rnd_data); end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL collide_timeout: got no grant want grant"); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_warmup();
    int  busy_cycles;
    bit  seen;
    do_reset();
    req_w       = 4'b0010;
    busy_cycles = (busy_w === 1'b1) ? 1 : 0;
    seen        = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (busy_w === 1'b1) busy_cycles++;
      if (rnd_valid_w === 1'b1) begin
        seen = 1'b1;
        total++; if (gnt_w !== 4'b0010) begin bad++; $display("FAIL warm_gnt: got %b want 0010", gnt_w); end
        total++; if (rnd_data_w !== 16'h5A93) begin bad++; $display("FAIL warm_data: got %h want 5a93", rnd_data_w); end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL warm_timeout: got no grant want grant"); end
    total++; if (busy_cycles != 2) begin bad++; $display("FAIL warm_busy: got %0d cycles want 2", busy_cycles); end
    req_w = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] nr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      nr         = 4'($urandom);
      req        = (req & ~e_gnt) | nr;
      seed_load  = ($urandom_range(0, 31) == 0);
      seed_value = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt, e_gnt); end
      total++; if (rnd_valid !== e_valid) begin bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, rnd_valid, e_valid); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, e_busy); end
      if (e_valid) begin
        total++; if (rnd_data !== e_data) begin bad++; $display("FAIL rand_data c=%0d: got %h want %h", c, rnd_data, e_data); end
      end
`ifdef LFSR_ARB_STATS_EN
      total++; if (grant_count !== e_cnt) begin bad++; $display("FAIL rand_count c=%0d: got %h want %h", c, grant_count, e_cnt); end
`endif
    end
    seed_load = 1'b0;
    req       = 4'b0000;
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) tick();
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", rnd_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt: got %b want 0000", gnt); end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", rnd_valid); end
    total++; if (rnd_data !== 16'h0000) begin bad++; $display("FAIL mid_data: got %h want 0000", rnd_data); end
`ifdef LFSR_ARB_STATS_EN
    total++; if (grant_count !== 16'h0000) begin bad++; $display("FAIL mid_count: got %h want 0000", grant_count); end
`endif
    #3;
    reset_n = 1'b1;
    model_reset();
    tick();
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_restart_gnt: got %b want 0001", gnt); end
    total++; if (rnd_data !== 16'h7449) begin bad++; $display("FAIL mid_restart_data: got %h want 7449", rnd_data); end
    tick();
    total++; if (gnt !== 4'b0010 || rnd_data !== 16'hE892) begin bad++; $display("FAIL mid_restart_next: got %b/%h want 0010/e892", gnt, rnd_data); end
    req = 4'b0000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_requester();
    test_round_robin();
    test_zero_seed();
    test_seed_collision();
    test_warmup();
    test_random();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
